des_iter_ctrl: RTL and testbench



---
 rtl/des_pkg.sv | 86 ++++++++
 rtl/DES_round.sv | 77 +++++++
 rtl/des_key_sched.sv | 59 +++++
 rtl/des_iter_ctrl.sv | 114 +++++++++++
 tb/tb_des_iter_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// DES constants shared by the iterative engine: permutation tables, key-shift
// schedule, controller state encoding and the bit-permutation helpers.
package des_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_e;

  localparam logic [4:0] FIRST_RND = 5'd1;
  localparam logic [4:0] LAST_RND  = 5'd16;

  // Tables use DES numbering: entry value 1 is the MSB of the source word.
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Index 0 holds the shift applied in round 1.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [63:0] ip(input logic [63:0] b);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = b[6'(64 - IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] b);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = b[6'(64 - FP_T[i])];
    return o;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return o;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd0:    return x;
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return {x[24:0], x[27:25]};
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd0:    return x;
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return {x[2:0], x[27:3]};
    endcase
  endfunction

endpackage

// File: rtl/DES_round.sv
// One combinational Feistel round: {L,R} -> {R, L ^ f(R, K)}.
module DES_round (
  input  logic [63:0] data_i,
  input  logic [47:0] key_i,
  output logic [63:0] data_o
);

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // Each box is stored row-major: entry {row, col}.
  localparam logic [3:0] SBOX [8][64] = '{
    '{4'd14,4'd4,4'd13,4'd1,4'd2,4'd15,4'd11,4'd8,4'd3,4'd10,4'd6,4'd12,4'd5,4'd9,4'd0,4'd7,
      4'd0,4'd15,4'd7,4'd4,4'd14,4'd2,4'd13,4'd1,4'd10,4'd6,4'd12,4'd11,4'd9,4'd5,4'd3,4'd8,
      4'd4,4'd1,4'd14,4'd8,4'd13,4'd6,4'd2,4'd11,4'd15,4'd12,4'd9,4'd7,4'd3,4'd10,4'd5,4'd0,
      4'd15,4'd12,4'd8,4'd2,4'd4,4'd9,4'd1,4'd7,4'd5,4'd11,4'd3,4'd14,4'd10,4'd0,4'd6,4'd13},
    '{4'd15,4'd1,4'd8,4'd14,4'd6,4'd11,4'd3,4'd4,4'd9,4'd7,4'd2,4'd13,4'd12,4'd0,4'd5,4'd10,
      4'd3,4'd13,4'd4,4'd7,4'd15,4'd2,4'd8,4'd14,4'd12,4'd0,4'd1,4'd10,4'd6,4'd9,4'd11,4'd5,
      4'd0,4'd14,4'd7,4'd11,4'd10,4'd4,4'd13,4'd1,4'd5,4'd8,4'd12,4'd6,4'd9,4'd3,4'd2,4'd15,
      4'd13,4'd8,4'd10,4'd1,4'd3,4'd15,4'd4,4'd2,4'd11,4'd6,4'd7,4'd12,4'd0,4'd5,4'd14,4'd9},
    '{4'd10,4'd0,4'd9,4'd14,4'd6,4'd3,4'd15,4'd5,4'd1,4'd13,4'd12,4'd7,4'd11,4'd4,4'd2,4'd8,
      4'd13,4'd7,4'd0,4'd9,4'd3,4'd4,4'd6,4'd10,4'd2,4'd8,4'd5,4'd14,4'd12,4'd11,4'd15,4'd1,
      4'd13,4'd6,4'd4,4'd9,4'd8,4'd15,4'd3,4'd0,4'd11,4'd1,4'd2,4'd12,4'd5,4'd10,4'd14,4'd7,
      4'd1,4'd10,4'd13,4'd0,4'd6,4'd9,4'd8,4'd7,4'd4,4'd15,4'd14,4'd3,4'd11,4'd5,4'd2,4'd12},
    '{4'd7,4'd13,4'd14,4'd3,4'd0,4'd6,4'd9,4'd10,4'd1,4'd2,4'd8,4'd5,4'd11,4'd12,4'd4,4'd15,
      4'd13,4'd8,4'd11,4'd5,4'd6,4'd15,4'd0,4'd3,4'd4,4'd7,4'd2,4'd12,4'd1,4'd10,4'd14,4'd9,
      4'd10,4'd6,4'd9,4'd0,4'd12,4'd11,4'd7,4'd13,4'd15,4'd1,4'd3,4'd14,4'd5,4'd2,4'd8,4'd4,
      4'd3,4'd15,4'd0,4'd6,4'd10,4'd1,4'd13,4'd8,4'd9,4'd4,4'd5,4'd11,4'd12,4'd7,4'd2,4'd14},
    '{4'd2,4'd12,4'd4,4'd1,4'd7,4'd10,4'd11,4'd6,4'd8,4'd5,4'd3,4'd15,4'd13,4'd0,4'd14,4'd9,
      4'd14,4'd11,4'd2,4'd12,4'd4,4'd7,4'd13,4'd1,4'd5,4'd0,4'd15,4'd10,4'd3,4'd9,4'd8,4'd6,
      4'd4,4'd2,4'd1,4'd11,4'd10,4'd13,4'd7,4'd8,4'd15,4'd9,4'd12,4'd5,4'd6,4'd3,4'd0,4'd14,
      4'd11,4'd8,4'd12,4'd7,4'd1,4'd14,4'd2,4'd13,4'd6,4'd15,4'd0,4'd9,4'd10,4'd4,4'd5,4'd3},
    '{4'd12,4'd1,4'd10,4'd15,4'd9,4'd2,4'd6,4'd8,4'd0,4'd13,4'd3,4'd4,4'd14,4'd7,4'd5,4'd11,
      4'd10,4'd15,4'd4,4'd2,4'd7,4'd12,4'd9,4'd5,4'd6,4'd1,4'd13,4'd14,4'd0,4'd11,4'd3,4'd8,
      4'd9,4'd14,4'd15,4'd5,4'd2,4'd8,4'd12,4'd3,4'd7,4'd0,4'd4,4'd10,4'd1,4'd13,4'd11,4'd6,
      4'd4,4'd3,4'd2,4'd12,4'd9,4'd5,4'd15,4'd10,4'd11,4'd14,4'd1,4'd7,4'd6,4'd0,4'd8,4'd13},
    '{4'd4,4'd11,4'd2,4'd14,4'd15,4'd0,4'd8,4'd13,4'd3,4'd12,4'd9,4'd7,4'd5,4'd10,4'd6,4'd1,
      4'd13,4'd0,4'd11,4'd7,4'd4,4'd9,4'd1,4'd10,4'd14,4'd3,4'd5,4'd12,4'd2,4'd15,4'd8,4'd6,
      4'd1,4'd4,4'd11,4'd13,4'd12,4'd3,4'd7,4'd14,4'd10,4'd15,4'd6,4'd8,4'd0,4'd5,4'd9,4'd2,
      4'd6,4'd11,4'd13,4'd8,4'd1,4'd4,4'd10,4'd7,4'd9,4'd5,4'd0,4'd15,4'd14,4'd2,4'd3,4'd12},
    '{4'd13,4'd2,4'd8,4'd4,4'd6,4'd15,4'd11,4'd1,4'd10,4'd9,4'd3,4'd14,4'd5,4'd0,4'd12,4'd7,
      4'd1,4'd15,4'd13,4'd8,4'd10,4'd3,4'd7,4'd4,4'd12,4'd5,4'd6,4'd11,4'd0,4'd14,4'd9,4'd2,
      4'd7,4'd11,4'd4,4'd1,4'd9,4'd12,4'd14,4'd2,4'd0,4'd6,4'd10,4'd13,4'd15,4'd3,4'd5,4'd8,
      4'd2,4'd1,4'd14,4'd7,4'd4,4'd10,4'd8,4'd13,4'd15,4'd12,4'd9,4'd0,4'd3,4'd5,4'd6,4'd11}};

  logic [31:0] left, right, sOut, fOut;
  logic [47:0] expR, mixed;
  logic [5:0]  six;

  assign left  = data_i[63:32];
  assign right = data_i[31:0];

  always_comb begin
    expR = '0;
    sOut = '0;
    fOut = '0;
    six  = '0;
    for (int i = 0; i < 48; i++) expR[6'(47 - i)] = right[5'(32 - E_T[i])];
    mixed = expR ^ key_i;
    // Outer bits of each 6-bit group pick the row, inner four the column.
    for (int b = 0; b < 8; b++) begin
      six = mixed[6'(47 - 6 * b) -: 6];
      sOut[5'(31 - 4 * b) -: 4] = SBOX[3'(b)][{six[5], six[0], six[4:1]}];
    end
    for (int i = 0; i < 32; i++) fOut[5'(31 - i)] = sOut[5'(32 - P_T[i])];
  end

  assign data_o = {right, left ^ fOut};

endmodule

// File: rtl/des_key_sched.sv
// On-the-fly DES key schedule: holds C/D and rotates them forwards for
// encryption or backwards for decryption, one round key per cycle.
module des_key_sched
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        advance_i,
  input  logic [4:0]  rnd_i,
  output logic [47:0] round_key_o
);

  logic [27:0] c_q, c_d, d_q, d_d, cRot, dRot;
  logic        dec_q, dec_d;
  logic [1:0]  shiftAmt;

  // Decryption walks the schedule backwards; round 1 reuses C0/D0 since
  // the full encrypt schedule rotates by 28 and lands back on the start.
  always_comb begin
    shiftAmt = 2'd0;
    if (rnd_i >= FIRST_RND && rnd_i <= LAST_RND) begin
      if (!dec_q) shiftAmt = SHIFT[4'(rnd_i - 5'd1)];
      else if (rnd_i != FIRST_RND) shiftAmt = SHIFT[4'(5'd17 - rnd_i)];
    end
    cRot = dec_q ? rotr28(c_q, shiftAmt) : rotl28(c_q, shiftAmt);
    dRot = dec_q ? rotr28(d_q, shiftAmt) : rotl28(d_q, shiftAmt);
  end

  assign round_key_o = pc2({cRot, dRot});

  always_comb begin
    c_d   = c_q;
    d_d   = d_q;
    dec_d = dec_q;
    if (load_i) begin
      {c_d, d_d} = pc1(key_i);
      dec_d      = decrypt_i;
    end else if (advance_i) begin
      c_d = cRot;
      d_d = dRot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      d_q   <= '0;
      dec_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      d_q   <= d_d;
      dec_q <= dec_d;
    end
  end

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES controller: accepts a job, runs 16 rounds through one
// DES_round, and holds the result until downstream takes it.
module des_iter_ctrl
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block
);

  state_e      state_q, state_d;
  logic [4:0]  rnd_q, rnd_d;
  logic [63:0] data_q, data_d;
  logic [63:0] out_block_q, out_block_d;
  logic        out_valid_q, out_valid_d;
  logic        accept, advance, rndOk;
  logic [47:0] roundKey;
  logic [63:0] roundOut;

  assign rndOk = (rnd_q >= FIRST_RND) && (rnd_q <= LAST_RND);

  des_key_sched u_key_sched (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .key_i       (in_key),
    .decrypt_i   (in_decrypt),
    .advance_i   (advance),
    .rnd_i       (rnd_q),
    .round_key_o (roundKey)
  );

  DES_round u_round (
    .data_i (data_q),
    .key_i  (roundKey),
    .data_o (roundOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      data_q      <= '0;
      out_block_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      data_q      <= data_d;
      out_block_q <= out_block_d;
      out_valid_q <= out_valid_d;
    end
  end

  // An out-of-range round count can only come from corruption; bail to IDLE.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    data_d      = data_q;
    out_block_d = out_block_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ROUND;
          data_d  = ip(in_block);
          rnd_d   = FIRST_RND;
        end
      end
      ROUND: begin
        if (!rndOk) begin
          state_d = IDLE;
          rnd_d   = '0;
        end else begin
          data_d = roundOut;
          if (rnd_q == LAST_RND) begin
            state_d     = DONE;
            out_block_d = fp({roundOut[31:0], roundOut[63:32]});
            out_valid_d = 1'b1;
          end else begin
            rnd_d = rnd_q + 5'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    accept   = in_ready && in_valid;
    advance  = (state_q == ROUND) && rndOk;
  end

  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Self-checking bench for des_iter_ctrl using known-answer DES vectors and
// a queue of expected results popped as each result is presented.
module tb_des_iter_ctrl;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] KW = 64'h0101010101010101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_block = '0;
  logic [63:0] in_key = '0;
  logic        in_decrypt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_block;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accCyc = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  des_iter_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_key     (in_key),
    .in_decrypt (in_decrypt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at a negedge with in_valid already high; returns at the negedge after the accept edge.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        accCyc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok, output int lat);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        ok  = 1'b1;
        lat = cyc - accCyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_job(input string name, input logic [63:0] key, input logic [63:0] blk,
                         input logic dec, input logic [63:0] exp);
    bit ok;
    int lat;
    logic [63:0] e;
    in_key = key; in_block = blk; in_decrypt = dec; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(exp);
    wait_accept(ok);
    in_valid = 1'b0;
    in_key = {$urandom, $urandom}; in_block = {$urandom, $urandom}; in_decrypt = ~dec;
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL %s accept: in_ready never seen, required within 60 cycles", name); end
    wait_valid(ok, lat);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL %s out_valid timeout: got none, required within 60 cycles", name); end
    tests++;
    if (lat != 16) begin fails++; $display("[TB] FAIL %s latency: got %0d, required 16", name, lat); end
    e = sb.pop_front();
    tests++;
    if (out_block !== e) begin fails++; $display("[TB] FAIL %s out_block: got %h, required %h", name, out_block, e); end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s handoff: out_valid=%b in_ready=%b, required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset in_ready: got %b, required 1", in_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset out_valid: got %b, required 0", out_valid); end
    tests++;
    if (out_block !== 64'h0) begin fails++; $display("[TB] FAIL reset out_block: got %h, required 0", out_block); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_encrypt_kat();
    run_job("enc_kat1", K1, P1, 1'b0, C1);
  endtask

  task automatic test_decrypt_kat();
    run_job("dec_kat1", K1, C1, 1'b1, P1);
  endtask

  task automatic test_second_kat();
    run_job("enc_kat2", K2, P2, 1'b0, C2);
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int c0;
    logic [63:0] held, e;
    bit stable, busyOk;
    in_key = K1; in_block = P1; in_decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back(C1);
    wait_accept(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL bp accept: in_ready never seen, required within 60 cycles"); end
    in_block = C1; in_decrypt = 1'b1; in_valid = 1'b1;
    sb.push_back(P1);
    wait_valid(ok, lat);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL bp out_valid timeout: got none, required within 60 cycles"); end
    held = out_block; stable = 1'b1; busyOk = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_block !== held || out_valid !== 1'b1) stable = 1'b0;
      if (in_ready !== 1'b0) busyOk = 1'b0;
    end
    tests++;
    if (!stable) begin fails++; $display("[TB] FAIL bp hold: out_block=%h out_valid=%b, required %h/1", out_block, out_valid, held); end
    tests++;
    if (!busyOk) begin fails++; $display("[TB] FAIL bp in_ready while DONE: got 1, required 0"); end
    e = sb.pop_front();
    tests++;
    if (out_block !== e) begin fails++; $display("[TB] FAIL bp out_block: got %h, required %h", out_block, e); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bp consume: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    c0 = cyc;
    wait_accept(ok);
    in_valid = 1'b0;
    tests++;
    if (!ok || accCyc != c0 + 1) begin
      fails++;
      $display("[TB] FAIL bp second accept: got cycle %0d, required %0d", accCyc, c0 + 1);
    end
    wait_valid(ok, lat);
    tests++;
    if (lat != 16) begin fails++; $display("[TB] FAIL bp second latency: got %0d, required 16", lat); end
    e = sb.pop_front();
    tests++;
    if (out_block !== e) begin fails++; $display("[TB] FAIL bp second out_block: got %h, required %h", out_block, e); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lat;
    int a0;
    logic [63:0] e;
    in_key = K2; in_block = P2; in_decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(C2);
    wait_accept(ok);
    a0 = accCyc;
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL b2b accept A: in_ready never seen, required within 60 cycles"); end
    in_key = K1; in_block = P1; in_decrypt = 1'b0; in_valid = 1'b1;
    sb.push_back(C1);
    wait_valid(ok, lat);
    e = sb.pop_front();
    tests++;
    if (out_block !== e || lat != 16) begin
      fails++;
      $display("[TB] FAIL b2b result A: got %h lat %0d, required %h lat 16", out_block, lat, e);
    end
    wait_accept(ok);
    in_valid = 1'b0;
    tests++;
    if (!ok || accCyc - a0 != 18) begin
      fails++;
      $display("[TB] FAIL b2b accept spacing: got %0d edges, required 18", accCyc - a0);
    end
    wait_valid(ok, lat);
    e = sb.pop_front();
    tests++;
    if (out_block !== e || lat != 16) begin
      fails++;
      $display("[TB] FAIL b2b result B: got %h lat %0d, required %h lat 16", out_block, lat, e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_weak_key();
    bit ok;
    int lat;
    logic [63:0] r1;
    in_key = KW; in_block = P1; in_decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    wait_valid(ok, lat);
    tests++;
    if (!ok || lat != 16) begin fails++; $display("[TB] FAIL weak first pass: got valid=%b lat %0d, required 1 lat 16", ok, lat); end
    r1 = out_block;
    tests++;
    if (r1 === P1) begin fails++; $display("[TB] FAIL weak first output: got %h, required a value other than %h", r1, P1); end
    @(posedge clk);
    @(negedge clk);
    run_job("weak_second", KW, r1, 1'b0, P1);
  endtask

  task automatic test_reset_midop();
    bit ok;
    bit quiet;
    in_key = K1; in_block = P1; in_decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midop reset: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin fails++; $display("[TB] FAIL midop partial result: out_valid got 1, required 0"); end
    run_job("kat_after_reset", K1, P1, 1'b0, C1);
  endtask

  initial begin
    test_reset();
    test_encrypt_kat();
    test_decrypt_kat();
    test_second_kat();
    test_backpressure();
    test_back_to_back();
    test_weak_key();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
